fpr_mp_sb: RTL and testbench

- Parametrised multi-port floating-point register file with an integrated scoreboard.
- Replaces the single-write-port FPR array; serves FMA-class instructions (three source operands) and concurrent FPU and load writebacks.
- Tracks per-register pending-write state so decode can stall on RAW/WAW hazards.
- Bypasses same-cycle writeback data to read ports.

---
 rtl/fpr_mp_sb.sv | 118 +++++++++++
 tb/tb_fpr_mp_sb.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpr_mp_sb.sv
// fpr_mp_sb: multi-port floating-point register file with an integrated
// pending-write scoreboard. Same-cycle writeback data is optionally forwarded
// to the combinational read ports; busy bits let decode stall on RAW/WAW.
module fpr_mp_sb #(
   parameter int NUM_REGS = 32,
   parameter int FLEN     = 32,
   parameter int NUM_RD   = 3,
   parameter int NUM_WR   = 2,
   parameter int BYPASS   = 1,
   parameter int ASZ      = $clog2(NUM_REGS)
) (
   input  logic                          clk_in,
   input  logic                          reset_in,
   input  logic [NUM_RD-1:0][ASZ-1:0]    rd_addr,
   output logic [NUM_RD-1:0][FLEN-1:0]   rd_data,
   output logic [NUM_RD-1:0]             rd_busy,
   input  logic                          iss_valid,
   input  logic [ASZ-1:0]                iss_addr,
   output logic                          iss_ready,
   input  logic [NUM_WR-1:0]             wr_en,
   input  logic [NUM_WR-1:0][ASZ-1:0]    wr_addr,
   input  logic [NUM_WR-1:0][FLEN-1:0]   wr_data,
   input  logic                          flush_in,
   output logic [$clog2(NUM_REGS+1)-1:0] pend_cnt
);

   localparam int CW = $clog2(NUM_REGS + 1);

   logic [FLEN-1:0]     regs   [NUM_REGS];
   logic [NUM_REGS-1:0] busy;
   logic [NUM_REGS-1:0] busy_nxt;
   logic [NUM_REGS-1:0] wr_hit;
   logic [FLEN-1:0]     wr_val [NUM_REGS];
   logic [CW-1:0]       cnt_nxt;
   logic                iss_ok;
   logic                iss_set;

   // Addresses at or above NUM_REGS only exist when NUM_REGS is not a power of two.
   function automatic logic in_range(input logic [ASZ-1:0] a);
      return {1'b0, a} < (ASZ + 1)'(NUM_REGS);
   endfunction

   // Per-register write select; ascending scan lets the highest-index port win.
   always_comb begin
      for (int unsigned k = 0; k < NUM_REGS; k++) begin
         wr_hit[k] = 1'b0;
         wr_val[k] = '0;
         for (int unsigned j = 0; j < NUM_WR; j++) begin
            if (wr_en[j] && (wr_addr[j] == ASZ'(k))) begin
               wr_hit[k] = 1'b1;
               wr_val[k] = wr_data[j];
            end
         end
      end
   end

   // Issue acceptance: a pending destination stalls unless it retires or a flush clears it now.
   always_comb begin
      iss_ok    = in_range(iss_addr);
      iss_ready = flush_in | ~iss_ok | ~busy[iss_addr] | wr_hit[iss_addr];
   end

   // Next-state busy vector (issue > flush > writeback clear > hold) and its popcount.
   always_comb begin
      busy_nxt = busy;
      cnt_nxt  = '0;
      iss_set  = iss_valid & iss_ready & iss_ok;
      for (int unsigned k = 0; k < NUM_REGS; k++) begin
         if (iss_set && (iss_addr == ASZ'(k))) begin
            busy_nxt[k] = 1'b1;
         end else if (flush_in) begin
            busy_nxt[k] = 1'b0;
         end else if (wr_hit[k]) begin
            busy_nxt[k] = 1'b0;
         end
         cnt_nxt = cnt_nxt + CW'(busy_nxt[k]);
      end
   end

   // Scoreboard state and pending count; reset overrides issue, flush and writeback.
   always_ff @(posedge clk_in) begin
      if (reset_in) begin
         busy     <= '0;
         pend_cnt <= '0;
      end else begin
         busy     <= busy_nxt;
         pend_cnt <= cnt_nxt;
      end
   end

   // Register array update; reset clears data even if a writeback is present.
   always_ff @(posedge clk_in) begin
      for (int unsigned k = 0; k < NUM_REGS; k++) begin
         if (reset_in) begin
            regs[k] <= '0;
         end else if (wr_hit[k]) begin
            regs[k] <= wr_val[k];
         end
      end
   end

   // Combinational read ports with optional same-cycle writeback forwarding.
   always_comb begin
      for (int unsigned i = 0; i < NUM_RD; i++) begin
         rd_data[i] = '0;
         rd_busy[i] = 1'b0;
         if (in_range(rd_addr[i])) begin
            if ((BYPASS != 0) && wr_hit[rd_addr[i]]) begin
               rd_data[i] = wr_val[rd_addr[i]];
            end else begin
               rd_data[i] = regs[rd_addr[i]];
               rd_busy[i] = busy[rd_addr[i]];
            end
         end
      end
   end

endmodule

// File: tb/tb_fpr_mp_sb.sv
// Bench for fpr_mp_sb: directed vector table and random traffic against a
// reference model on a 32x32 bypassing build, plus hand sequences on a
// 16x64 non-bypassing build.
module tb_fpr_mp_sb;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Build A: NUM_REGS=32, FLEN=32, BYPASS=1
   logic             a_rst, a_iv, a_fl, a_ready;
   logic [4:0]       a_ia;
   logic [2:0][4:0]  a_ra;
   logic [2:0][31:0] a_rd;
   logic [2:0]       a_rb;
   logic [1:0]       a_we;
   logic [1:0][4:0]  a_wa;
   logic [1:0][31:0] a_wd;
   logic [5:0]       a_cnt;

   // Build B: NUM_REGS=16, FLEN=64, BYPASS=0
   logic             b_rst, b_iv, b_fl, b_ready;
   logic [3:0]       b_ia;
   logic [2:0][3:0]  b_ra;
   logic [2:0][63:0] b_rd;
   logic [2:0]       b_rb;
   logic [1:0]       b_we;
   logic [1:0][3:0]  b_wa;
   logic [1:0][63:0] b_wd;
   logic [4:0]       b_cnt;

   fpr_mp_sb #(.NUM_REGS(32), .FLEN(32), .NUM_RD(3), .NUM_WR(2), .BYPASS(1)) dut_a (
      .clk_in(clk), .reset_in(a_rst),
      .rd_addr(a_ra), .rd_data(a_rd), .rd_busy(a_rb),
      .iss_valid(a_iv), .iss_addr(a_ia), .iss_ready(a_ready),
      .wr_en(a_we), .wr_addr(a_wa), .wr_data(a_wd),
      .flush_in(a_fl), .pend_cnt(a_cnt)
   );

   fpr_mp_sb #(.NUM_REGS(16), .FLEN(64), .NUM_RD(3), .NUM_WR(2), .BYPASS(0)) dut_b (
      .clk_in(clk), .reset_in(b_rst),
      .rd_addr(b_ra), .rd_data(b_rd), .rd_busy(b_rb),
      .iss_valid(b_iv), .iss_addr(b_ia), .iss_ready(b_ready),
      .wr_en(b_we), .wr_addr(b_wa), .wr_data(b_wd),
      .flush_in(b_fl), .pend_cnt(b_cnt)
   );

   typedef struct {
      string       name;
      int          rst, iv, ia, fl, we;
      int          wa0, wa1;
      logic [31:0] wd0, wd1;
      int          ra0, ra1, ra2;
      logic [31:0] e0, e1, e2;
      int          b0, b1, b2;
      int          er, ec;
   } vec_t;

   vec_t vq[$];

   task automatic add(input string name, input int rst, input int iv, input int ia,
                      input int fl, input int we, input int wa0, input logic [31:0] wd0,
                      input int wa1, input logic [31:0] wd1,
                      input int ra0, input int ra1, input int ra2,
                      input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] e2,
                      input int b0, input int b1, input int b2, input int er, input int ec);
      vec_t v;
      v.name = name; v.rst = rst; v.iv = iv; v.ia = ia; v.fl = fl; v.we = we;
      v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1;
      v.ra0 = ra0; v.ra1 = ra1; v.ra2 = ra2;
      v.e0 = e0; v.e1 = e1; v.e2 = e2;
      v.b0 = b0; v.b1 = b1; v.b2 = b2; v.er = er; v.ec = ec;
      vq.push_back(v);
   endtask

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [4:0] raddr();
      if ($urandom_range(0, 3) != 0) return 5'($urandom_range(0, 7));
      return 5'($urandom_range(0, 31));
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] m_reg [32];
      bit          m_busy [32];
      logic [31:0] ed;
      bit          eb, er, found;
      int          n;

      a_rst = 1'b1; a_iv = 1'b0; a_ia = '0; a_fl = 1'b0; a_we = '0; a_wa = '0; a_wd = '0; a_ra = '0;
      b_rst = 1'b1; b_iv = 1'b0; b_ia = '0; b_fl = 1'b0; b_we = '0; b_wa = '0; b_wd = '0; b_ra = '0;
      tick();
      tick();
      a_rst = 1'b0;
      b_rst = 1'b0;

      // name           rst iv ia fl  we  wa0 wd0            wa1 wd1           ra0 ra1 ra2  e0             e1             e2             b0 b1 b2 rdy cnt
      add("rst_state",    0, 0, 0, 0, 0,  0, 0,             0, 0,             0,  5, 31,  0,             0,             0,             0, 0, 0, 1, 0);
      add("iss_f5",       0, 1, 5, 0, 0,  0, 0,             0, 0,             5,  0, 31,  0,             0,             0,             0, 0, 0, 1, 0);
      add("reiss_f5",     0, 1, 5, 0, 0,  0, 0,             0, 0,             5,  0, 31,  0,             0,             0,             1, 0, 0, 0, 1);
      add("wb_f5",        0, 0, 5, 0, 1,  5, 32'h3F800000,  0, 0,             5,  0, 31,  32'h3F800000,  0,             0,             0, 0, 0, 1, 1);
      add("f5_clr",       0, 0, 5, 0, 0,  0, 0,             0, 0,             5,  0, 31,  32'h3F800000,  0,             0,             0, 0, 0, 1, 0);
      add("f7_dual",      0, 0, 0, 0, 3,  7, 32'h11111111,  7, 32'h22222222,  7,  5,  0,  32'h22222222,  32'h3F800000,  0,             0, 0, 0, 1, 0);
      add("f7_after",     0, 0, 0, 0, 0,  0, 0,             0, 0,             7,  5,  0,  32'h22222222,  32'h3F800000,  0,             0, 0, 0, 1, 0);
      add("iss_f3",       0, 1, 3, 0, 0,  0, 0,             0, 0,             3,  4,  9,  0,             0,             0,             0, 0, 0, 1, 0);
      add("iss_f4",       0, 1, 4, 0, 0,  0, 0,             0, 0,             3,  4,  9,  0,             0,             0,             1, 0, 0, 1, 1);
      add("iss_f9",       0, 1, 9, 0, 0,  0, 0,             0, 0,             3,  4,  9,  0,             0,             0,             1, 1, 0, 1, 2);
      add("flush_iss12",  0, 1, 12, 1, 0, 0, 0,             0, 0,             3,  4,  9,  0,             0,             0,             1, 1, 1, 1, 3);
      add("after_flush",  0, 0, 12, 0, 0, 0, 0,             0, 0,             12, 7,  5,  0,             32'h22222222,  32'h3F800000,  1, 0, 0, 0, 1);
      add("iss_f1",       0, 1, 1, 0, 0,  0, 0,             0, 0,             12, 1,  6,  0,             0,             0,             1, 0, 0, 1, 1);
      add("iss_f6",       0, 1, 6, 0, 0,  0, 0,             0, 0,             1, 12,  6,  0,             0,             0,             1, 1, 0, 1, 2);
      add("rst_mid",      1, 0, 6, 0, 1,  6, 32'hAAAA5555,  0, 0,             6,  1, 12,  32'hAAAA5555,  0,             0,             0, 1, 1, 1, 3);
      add("post_rst",     0, 0, 6, 0, 0,  0, 0,             0, 0,             6,  7,  5,  0,             0,             0,             0, 0, 0, 1, 0);
      add("iss_f8",       0, 1, 8, 0, 0,  0, 0,             0, 0,             8,  0,  0,  0,             0,             0,             0, 0, 0, 1, 0);
      add("iss_wb_f8",    0, 1, 8, 0, 1,  8, 32'h12345678,  0, 0,             8,  0,  0,  32'h12345678,  0,             0,             0, 0, 0, 1, 1);
      add("f8_iss_won",   0, 0, 8, 0, 0,  0, 0,             0, 0,             8,  0,  0,  32'h12345678,  0,             0,             1, 0, 0, 0, 1);
      add("flush_f8",     0, 0, 8, 1, 0,  0, 0,             0, 0,             8,  0,  0,  32'h12345678,  0,             0,             1, 0, 0, 1, 1);
      add("flush_done",   0, 0, 8, 0, 0,  0, 0,             0, 0,             8,  0,  0,  32'h12345678,  0,             0,             0, 0, 0, 1, 0);

      foreach (vq[x]) begin
         a_rst = vq[x].rst[0]; a_iv = vq[x].iv[0]; a_ia = 5'(vq[x].ia); a_fl = vq[x].fl[0];
         a_we = 2'(vq[x].we);
         a_wa[0] = 5'(vq[x].wa0); a_wd[0] = vq[x].wd0;
         a_wa[1] = 5'(vq[x].wa1); a_wd[1] = vq[x].wd1;
         a_ra[0] = 5'(vq[x].ra0); a_ra[1] = 5'(vq[x].ra1); a_ra[2] = 5'(vq[x].ra2);
         #4;
         chk({vq[x].name, "_rd0"}, 64'(a_rd[0]), 64'(vq[x].e0));
         chk({vq[x].name, "_rd1"}, 64'(a_rd[1]), 64'(vq[x].e1));
         chk({vq[x].name, "_rd2"}, 64'(a_rd[2]), 64'(vq[x].e2));
         chk({vq[x].name, "_busy0"}, 64'(a_rb[0]), 64'(vq[x].b0));
         chk({vq[x].name, "_busy1"}, 64'(a_rb[1]), 64'(vq[x].b1));
         chk({vq[x].name, "_busy2"}, 64'(a_rb[2]), 64'(vq[x].b2));
         chk({vq[x].name, "_ready"}, 64'(a_ready), 64'(vq[x].er));
         chk({vq[x].name, "_cnt"}, 64'(a_cnt), 64'(vq[x].ec));
         tick();
      end

      // Random traffic against the reference model
      a_rst = 1'b1; a_iv = 1'b0; a_fl = 1'b0; a_we = '0;
      tick();
      a_rst = 1'b0;
      for (int k = 0; k < 32; k++) begin
         m_reg[k] = '0;
         m_busy[k] = 1'b0;
      end
      for (int c = 0; c < 600; c++) begin
         a_rst = ($urandom_range(0, 99) == 0);
         a_iv  = 1'($urandom_range(0, 1));
         a_ia  = raddr();
         a_fl  = ($urandom_range(0, 24) == 0);
         a_we  = 2'($urandom_range(0, 3));
         for (int j = 0; j < 2; j++) begin
            a_wa[j] = raddr();
            a_wd[j] = $urandom;
         end
         for (int i = 0; i < 3; i++) a_ra[i] = raddr();
         #4;
         for (int i = 0; i < 3; i++) begin
            found = 1'b0;
            ed = m_reg[a_ra[i]];
            eb = m_busy[a_ra[i]];
            for (int j = 1; j >= 0; j--) begin
               if (!found && a_we[j] && a_wa[j] == a_ra[i]) begin
                  found = 1'b1;
                  ed = a_wd[j];
                  eb = 1'b0;
               end
            end
            chk($sformatf("rnd_rd%0d", i), 64'(a_rd[i]), 64'(ed));
            chk($sformatf("rnd_busy%0d", i), 64'(a_rb[i]), 64'(eb));
         end
         er = !m_busy[a_ia] || a_fl || (a_we[0] && a_wa[0] == a_ia) || (a_we[1] && a_wa[1] == a_ia);
         chk("rnd_ready", 64'(a_ready), 64'(er));
         n = 0;
         for (int k = 0; k < 32; k++) if (m_busy[k]) n++;
         chk("rnd_cnt", 64'(a_cnt), 64'(n));
         if (a_rst) begin
            for (int k = 0; k < 32; k++) begin
               m_reg[k] = '0;
               m_busy[k] = 1'b0;
            end
         end else begin
            for (int j = 0; j < 2; j++) if (a_we[j]) m_reg[a_wa[j]] = a_wd[j];
            if (a_fl) begin
               for (int k = 0; k < 32; k++) m_busy[k] = 1'b0;
            end else begin
               for (int j = 0; j < 2; j++) if (a_we[j]) m_busy[a_wa[j]] = 1'b0;
            end
            if (a_iv && er) m_busy[a_ia] = 1'b1;
         end
         tick();
      end
      a_rst = 1'b0; a_iv = 1'b0; a_fl = 1'b0; a_we = '0;

      // Build B: 16 registers, 64-bit, no forwarding
      b_ra[0] = 4'd0; b_ra[1] = 4'd5; b_ra[2] = 4'd15;
      #4;
      chk("b_rst_rd0", b_rd[0], 64'd0);
      chk("b_rst_rd2", b_rd[2], 64'd0);
      chk("b_rst_busy", 64'(b_rb), 64'd0);
      chk("b_rst_cnt", 64'(b_cnt), 64'd0);
      chk("b_rst_ready", 64'(b_ready), 64'd1);
      tick();
      b_we = 2'b01; b_wa[0] = 4'd2; b_wd[0] = 64'h0123_4567_DEAD_BEEF; b_ra[0] = 4'd2;
      #4;
      chk("b_nobypass_rd", b_rd[0], 64'd0);
      tick();
      b_we = 2'b00;
      #4;
      chk("b_wr_visible", b_rd[0], 64'h0123_4567_DEAD_BEEF);
      tick();
      b_iv = 1'b1; b_ia = 4'd1;
      tick();
      b_ia = 4'd6;
      tick();
      b_iv = 1'b0;
      b_ra[0] = 4'd6; b_ra[1] = 4'd1; b_ra[2] = 4'd2;
      #4;
      chk("b_busy6", 64'(b_rb[0]), 64'd1);
      chk("b_busy1", 64'(b_rb[1]), 64'd1);
      chk("b_cnt2", 64'(b_cnt), 64'd2);
      tick();
      b_rst = 1'b1; b_we = 2'b01; b_wa[0] = 4'd6; b_wd[0] = '1;
      #4;
      chk("b_rstwr_rd6", b_rd[0], 64'd0);
      chk("b_rstwr_busy6", 64'(b_rb[0]), 64'd1);
      chk("b_rstwr_ready", 64'(b_ready), 64'd1);
      tick();
      b_rst = 1'b0; b_we = 2'b00;
      #4;
      chk("b_post_rd6", b_rd[0], 64'd0);
      chk("b_post_rd2", b_rd[2], 64'd0);
      chk("b_post_busy", 64'(b_rb), 64'd0);
      chk("b_post_cnt", 64'(b_cnt), 64'd0);
      tick();
      b_we = 2'b11; b_wa[0] = 4'd3; b_wa[1] = 4'd3;
      b_wd[0] = 64'hAAAA_AAAA_AAAA_AAAA; b_wd[1] = 64'h8000_0000_0000_0001;
      tick();
      b_we = 2'b00; b_ra[0] = 4'd3;
      #4;
      chk("b_dual_wr", b_rd[0], 64'h8000_0000_0000_0001);
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
